// File: rtl/ibus_responder_if.sv
// Instruction-bus request/response types and the bus interface between fetch and I-memory.
// Latency: none (wiring only).
// Backpressure: the responder holds off by delaying addr_ok/data_ok; the initiator keeps valid high until then.
package ibus_pkg;
   // Reset/boot fetch address; word 0 of the instruction array sits here by default.
   localparam logic [31:0] PCINIT = 32'h1c00_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;
endpackage

interface ibus_responder_if;
   import ibus_pkg::*;

   ibus_req_t  ireq;
   ibus_resp_t iresp;

   modport master (output ireq, input iresp);
   modport slave  (input ireq, output iresp);
endinterface

// File: rtl/ibus_responder.sv
// Instruction-bus responder backed by a word array with a backdoor load port; one request at a time.
// Latency: addr_ok/data_ok pulse LATENCY cycles after the request is accepted, then one idle cycle.
// Backpressure: no new request is accepted until IDLE; dropping valid during the wait aborts the fetch.
module ibus_responder
   import ibus_pkg::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR = PCINIT,
   parameter int          LATENCY   = 2,
   localparam int         AW        = $clog2(MEM_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   ibus_responder_if.slave  bus,
   input  logic             load_en,
   input  logic [AW-1:0]    load_idx,
   input  logic [31:0]      load_data,
   output logic             err,
   output logic [31:0]      served_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [31:0] addr_q;
   logic [3:0]  cnt;
   ibus_resp_t  resp_q;

   logic [31:0] mem [MEM_WORDS];

   logic [31:0] rd_addr;
   logic [31:0] rd_off;
   logic        rd_bad;
   logic [AW-1:0] rd_idx;
   logic [31:0] rd_word;

   assign bus.iresp = resp_q;

   // Decode the address being served: the live request when accepting straight into RESP, else the latched one.
   always_comb begin
      rd_addr = (state == IDLE) ? bus.ireq.addr : addr_q;
      rd_off  = rd_addr - BASE_ADDR;
      rd_bad  = (rd_addr < BASE_ADDR) || (rd_addr[1:0] != 2'b00) ||
                ((rd_off >> 2) >= 32'(MEM_WORDS));
      rd_idx  = rd_off[AW+1:2];
      rd_word = rd_bad ? 32'h0000_0000 : mem[rd_idx];
   end

   // Backdoor load; the read above samples the pre-write value on a colliding edge.
   always_ff @(posedge clk) begin
      if (load_en)
         mem[load_idx] <= load_data;
   end

   // Request FSM with registered handshake, data, sticky error and completion counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         addr_q     <= '0;
         cnt        <= '0;
         resp_q     <= '0;
         err        <= 1'b0;
         served_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               resp_q <= '0;
               if (bus.ireq.valid) begin
                  addr_q <= bus.ireq.addr;
                  cnt    <= 4'(LATENCY - 1);
                  if (LATENCY == 1) begin
                     state  <= RESP;
                     resp_q <= '{addr_ok: 1'b1, data_ok: 1'b1, data: rd_word};
                     if (rd_bad)
                        err <= 1'b1;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!bus.ireq.valid) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == 4'd1) begin
                  state  <= RESP;
                  cnt    <= '0;
                  resp_q <= '{addr_ok: 1'b1, data_ok: 1'b1, data: rd_word};
                  if (rd_bad)
                     err <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_q     <= '0;
               served_cnt <= served_cnt + 32'd1;
            end
            default: begin
               state  <= IDLE;
               resp_q <= '0;
            end
         endcase
      end
   end

endmodule
